// File: rtl/bsg_two_fifo_if.sv
// Handshake bundle for bsg_two_fifo: a valid/ready producer side and a
// valid/yumi consumer side.
interface bsg_two_fifo_if #(
    parameter int width_p = 16
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with zero-latency head output and no data_i bypass.
// State is carried entirely by the write/read pointers and the full flag.
module bsg_two_fifo #(
    parameter int width_p                 = 16,
    parameter int ready_THEN_valid_p      = 0,
    parameter int allow_enq_deq_on_full_p = 0
) (
    input  logic           clk_i,
    input  logic           reset_i,
    bsg_two_fifo_if.slave  link
);

    logic               wptr_r;
    logic               rptr_r;
    logic               full_r;
    logic [width_p-1:0] mem_r [2];

    logic               ready;
    logic               enq;
    logic               deq;
    logic               full_n;

    always_comb begin
        ready = ~full_r;
        if (allow_enq_deq_on_full_p != 0)
            ready = ~full_r | link.yumi_i;

        enq = link.v_i & ready;
        if (ready_THEN_valid_p != 0)
            enq = link.v_i;

        deq = link.yumi_i;

        // Full only when a lone enqueue makes the pointers meet again.
        full_n = full_r;
        if (enq && !deq && ((~wptr_r) == rptr_r))
            full_n = 1'b1;
        else if (deq && !enq)
            full_n = 1'b0;
    end

    assign link.ready_o = ready;
    assign link.v_o     = full_r | (wptr_r != rptr_r);
    assign link.data_o  = mem_r[rptr_r];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= 1'b0;
            rptr_r <= 1'b0;
            full_r <= 1'b0;
        end else begin
            wptr_r <= wptr_r ^ enq;
            rptr_r <= rptr_r ^ deq;
            full_r <= full_n;
        end
    end

    // Storage is never reset; pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wptr_r] <= link.data_i;
    end

    a_no_yumi_when_empty: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(link.yumi_i && !link.v_o)
    );

    a_no_enq_when_not_ready: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !((ready_THEN_valid_p != 0) && link.v_i && !link.ready_o)
    );

endmodule

// File: doc/bsg_two_fifo.md
BSG_TWO_FIFO -- requirements
Module: bsg_two_fifo

Interface
- REQ-001: Parameter width_p, default 16, SHALL set the data width in bits.
- REQ-002: Parameter ready_THEN_valid_p, default 0, SHALL select the enqueue rule when 1: producer asserts v_i only when ready_o=1, so enqueue = v_i.
- REQ-003: Parameter allow_enq_deq_on_full_p, default 0, SHALL, when 1, let ready_o assert while full if yumi_i=1 in the same cycle.
- REQ-004: clk_i  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-005: reset_i  input  1  reset; synchronous, active-high.
- REQ-006: v_i  input  1  producer data valid.
- REQ-007: data_i  input  width_p  producer data.
- REQ-008: ready_o  output  1  FIFO can accept data this cycle.
- REQ-009: v_o  output  1  head entry valid.
- REQ-010: data_o  output  width_p  head entry data.
- REQ-011: yumi_i  input  1  consumer takes head this cycle; legal only when v_o=1.

Function
- REQ-012: Storage SHALL be exactly two width_p-bit entries, with 1-bit write pointer wptr, 1-bit read pointer rptr and a 1-bit full flag.
- REQ-013: State SHALL be EMPTY (wptr==rptr, full=0), ONE (wptr!=rptr), or FULL (wptr==rptr, full=1).
- REQ-014: enq SHALL be v_i & ready_o when ready_THEN_valid_p=0, and v_i when ready_THEN_valid_p=1.
- REQ-015: deq SHALL equal yumi_i.
- REQ-016: ready_o SHALL be ~full, or ~full | yumi_i when allow_enq_deq_on_full_p=1.
- REQ-017: v_o SHALL be 1 exactly when the state is ONE or FULL.
- REQ-018: data_o SHALL equal entry[rptr], combinationally, with no bypass from data_i: zero-latency output, one-cycle minimum enq-to-v_o latency.
- REQ-019: On enq, entry[wptr] SHALL be written with data_i and wptr SHALL toggle; on deq, rptr SHALL toggle.
- REQ-020: Transitions: EMPTY+enq -> ONE; ONE+enq only -> FULL; ONE+deq only -> EMPTY; ONE+enq+deq -> ONE; FULL+deq -> ONE; FULL+enq+deq (allowed only when allow_enq_deq_on_full_p=1) -> FULL; no enq and no deq -> no state change.
- REQ-021: full SHALL set when enq & ~deq & the next wptr equals rptr, clear on deq & ~enq, and hold otherwise.
- REQ-022: Pointer wrap SHALL be natural 1-bit toggle from 1 to 0; ordering SHALL be strict FIFO.
- REQ-023: Entries SHALL not be reset; data_o content is don't-care while v_o=0.
- REQ-024: yumi_i while v_o=0, or enqueue while ready_o=0, SHALL be a protocol violation flagged by a simulation-only assertion; no state is defined after a violation.

Reset
- REQ-025: While reset_i=1 at a rising edge, wptr, rptr and full SHALL clear to 0 regardless of v_i or yumi_i.
- REQ-026: During and after reset, before any enq, outputs SHALL be v_o=0 and ready_o=1; data_o is not reset.
- REQ-027: Reset asserted mid-operation (ONE or FULL) SHALL discard all stored entries; v_o=0 on the cycle after the reset edge.

Verification
- REQ-028: Reset, then v_i=1 with data_i=0x1234 for one cycle -> next cycle v_o=1, data_o=0x1234, ready_o=1.
- REQ-029: Enqueue 0xAAAA, then 0x5555 with yumi_i=0 -> ready_o=0 (FULL); v_i held at 0xFFFF causes no write; yumi_i pops in order 0xAAAA, 0x5555; then v_o=0.
- REQ-030: In ONE holding 0x0001, enq 0x0002 with yumi_i=1 in the same cycle -> stays ONE, data_o=0x0002 next cycle.
- REQ-031: allow_enq_deq_on_full_p=1, FULL with 0x0010 and 0x0020, v_i=1 with 0x0030 and yumi_i=1 -> ready_o=1 that cycle; stays FULL; pop order 0x0020, 0x0030.
- REQ-032: FULL, reset_i=1 for one cycle with v_i=1 -> v_o=0, ready_o=1 after reset; nothing enqueued during reset.
- REQ-033: Random v_i/yumi_i for at least 10k cycles against a scoreboard queue -> no ordering mismatch, no loss or duplication, and no assertion fires.
